queen_controller: RTL and testbench
===================================

// Module: queen_controller
// PURPOSE
//   Backtracking FSM for the 8-queen solver; sits directly upstream of the 8-queen datapath and drives all of its strobes.
//   Walks rows, shifts/advances/backtracks queens from datapath status, and streams each solution's 8 rows onto out_bus
//   with a valid/ready handshake. Counts solutions and flags completion to the top level.
//   Datapath contract: reset_counter clears board, row=0, queen row0 at col0; count_up: row+1, new row queen at col0;
//   count_down: row-1; shift_right: current queen one column right; cout: row==7; last_queen_counter_zero: row==0;
//   last_cell: current queen at col7; safe: current queen unattacked by rows above; load_counter: down cnt=7;
//   count: down cnt-1; enable_output: out_bus = row[down cnt]; down_counter_zero: down cnt==0.
// PARAMETERS
//   FIND_ALL  1  1: continue search after each solution until exhausted; 0: stop after first solution
//   SOL_W     7  width of solution_count (saturating)
// PORTS
//   clk                      in   1      rising-edge clock
//   rst                      in   1      synchronous, active-high reset
//   start                    in   1      begin search; sampled only in IDLE or DONE
//   out_ready                in   1      downstream accepts current out_bus row
//   cout                     in   1      datapath: current row is row 7
//   down_counter_zero        in   1      datapath: output down counter == 0
//   last_queen_counter_zero  in   1      datapath: current row is row 0
//   last_cell                in   1      datapath: current queen in column 7
//   safe                     in   1      datapath: current queen unattacked
//   reset_counter            out  1      strobe to datapath
//   count_up / count_down    out  1      row counter strobes (never both high)
//   shift_right              out  1      move current queen right
//   load_counter / count     out  1      output down-counter load / decrement
//   enable_output            out  1      drive out_bus from datapath
//   out_valid                out  1      out_bus holds a valid solution row
//   out_last                 out  1      with out_valid: final row of this solution (row 0)
//   busy                     out  1      high in every state except IDLE/DONE
//   done                     out  1      search finished; held until next start
//   solution_count           out  SOL_W  solutions found since last start
// BEHAVIOUR
//   Reset: state IDLE; all strobes, out_valid, out_last, busy, done = 0; solution_count = 0.
//   Strobes are Mealy, decoded from state + inputs; at most one datapath strobe per cycle.
//   IDLE/DONE: start -> reset_counter=1, solution_count<=0, done<=0, goto CHECK.
//   CHECK: safe & cout -> load_counter=1, solution_count+1 (saturate at all-ones), goto STREAM.
//          safe & !cout -> count_up=1, stay CHECK.  !safe & !last_cell -> shift_right=1, stay CHECK.
//          !safe & last_cell -> goto NEXT (no strobe).
//   NEXT:  last_cell & !last_queen_counter_zero -> count_down=1, stay NEXT.
//          last_cell & last_queen_counter_zero -> goto DONE (space exhausted).
//          !last_cell -> shift_right=1, goto CHECK.
//   STREAM: enable_output=out_valid=1; out_last = down_counter_zero; rows emitted 7 down to 0.
//          out_ready=0: hold, no strobes, out_bus stable.  out_ready & !down_counter_zero -> count=1.
//          out_ready & down_counter_zero -> FIND_ALL ? goto NEXT : goto DONE.
//   DONE: done=1, busy=0. Latency start->first CHECK eval: 1 cycle.
//   start while busy ignored. rst in any state (incl. mid-STREAM) returns to IDLE next edge; out_valid drops same edge.
//   solution_count stable during and after search; cleared only by rst or accepted start.
// TESTING
//   rst mid-search then idle -> all outputs 0, solution_count 0, state IDLE.
//   start, FIND_ALL=0, out_ready=1, real datapath -> rows 7..0 cols 3,1,6,2,5,7,4,0; out_last on row0; done=1; count=1.
//   start, FIND_ALL=1, out_ready=1 -> exactly 92 solutions (736 valid beats), solution_count=92, done=1.
//   out_ready low 5 cycles mid-STREAM -> out_bus/out_valid held, no count strobe, no beat lost or duplicated.
//   start asserted while busy -> ignored; solution_count unaffected; search completes normally.
//   Every cycle: assert at most one datapath strobe, never count_up with count_down.

Source files
------------

// File: rtl/queen_if.sv
// queen_if: controller/datapath strobes and status plus the solution-row valid/ready handshake
// master: controller side (drives strobes, out_valid, out_last; reads status, out_ready)
// slave:  datapath/downstream side
interface queen_if;
  logic reset_counter;
  logic count_up;
  logic count_down;
  logic shift_right;
  logic load_counter;
  logic count;
  logic enable_output;
  logic cout;
  logic down_counter_zero;
  logic last_queen_counter_zero;
  logic last_cell;
  logic safe;
  logic out_valid;
  logic out_last;
  logic out_ready;
  modport master (
    output reset_counter, count_up, count_down, shift_right, load_counter, count, enable_output,
    output out_valid, out_last,
    input  cout, down_counter_zero, last_queen_counter_zero, last_cell, safe, out_ready
  );
  modport slave (
    input  reset_counter, count_up, count_down, shift_right, load_counter, count, enable_output,
    input  out_valid, out_last,
    output cout, down_counter_zero, last_queen_counter_zero, last_cell, safe, out_ready
  );
endinterface

// File: rtl/queen_controller.sv
// queen_controller: backtracking FSM driving the 8-queen datapath and streaming each solution
// ports: clk, rst (sync, active-high), start; io (queen_if.master) carries datapath strobes/status
// and the out_valid/out_ready/out_last row stream; busy, done, solution_count (saturating) to top level
module queen_controller #(
  parameter bit FIND_ALL = 1'b1,
  parameter int SOL_W    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  queen_if.master          io,
  output logic             busy,
  output logic             done,
  output logic [SOL_W-1:0] solution_count
);
  typedef enum logic [2:0] {IDLE, CHECK, NEXT, STREAM, DONE} state_t;
  state_t           state_q, state_d;
  logic [SOL_W-1:0] sol_q, sol_d;
  always_comb begin
    state_d          = state_q;
    sol_d            = sol_q;
    io.reset_counter = 1'b0;
    io.count_up      = 1'b0;
    io.count_down    = 1'b0;
    io.shift_right   = 1'b0;
    io.load_counter  = 1'b0;
    io.count         = 1'b0;
    io.enable_output = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        io.reset_counter = 1'b1;
        sol_d            = '0;
        state_d          = CHECK;
      end
      CHECK: if (io.safe && io.cout) begin
        io.load_counter = 1'b1;
        sol_d           = &sol_q ? sol_q : sol_q + SOL_W'(1);
        state_d         = STREAM;
      end else if (io.safe) io.count_up = 1'b1;
      else if (!io.last_cell) io.shift_right = 1'b1;
      else state_d = NEXT;
      // Backtrack upward while the row's queen has no column left to try.
      NEXT: if (!io.last_cell) begin
        io.shift_right = 1'b1;
        state_d        = CHECK;
      end else if (!io.last_queen_counter_zero) io.count_down = 1'b1;
      else state_d = DONE;
      STREAM: begin
        io.enable_output = 1'b1;
        io.count         = io.out_ready && !io.down_counter_zero;
        state_d          = io.out_ready && io.down_counter_zero ? (FIND_ALL ? NEXT : DONE) : STREAM;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sol_q   <= '0;
    end else begin
      state_q <= state_d;
      sol_q   <= sol_d;
    end
  end
  assign io.out_valid    = state_q == STREAM;
  assign io.out_last     = state_q == STREAM && io.down_counter_zero;
  assign busy            = state_q != IDLE && state_q != DONE;
  assign done            = state_q == DONE;
  assign solution_count  = sol_q;
endmodule

// File: tb/tb_queen_controller.sv
// tb_queen_controller: two controllers (stop-at-first and find-all) on behavioural datapaths, checked against a solution list
module tb_queen_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic       start_v [2];
  logic       ready_v [2];
  logic       valid_v [2];
  logic       last_v  [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic [6:0] stb_v   [2];
  logic [2:0] bus_v   [2];
  logic [6:0] sc_v    [2];
  int         n_chk = 0;
  int         n_fail = 0;
  int         sols [92][8];
  int         nsol;
  int         bcnt [2];
  bit         hold [2];
  logic [2:0] pbus [2];
  logic       plast [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : inst
    queen_if    qi ();
    logic [2:0] cols [8];
    logic [2:0] row;
    logic [2:0] dcnt;
    logic       safe_c;
    int         dc;
    queen_controller #(.FIND_ALL(g == 1), .SOL_W(7)) dut (
      .clk(clk), .rst(rst), .start(start_v[g]), .io(qi),
      .busy(busy_v[g]), .done(done_v[g]), .solution_count(sc_v[g])
    );
    always_comb begin
      safe_c = 1'b1;
      dc     = 0;
      for (int r = 0; r < 8; r++)
        if (r < int'(row)) begin
          dc = int'(cols[r]) - int'(cols[row]);
          if (dc == 0 || dc == int'(row) - r || -dc == int'(row) - r) safe_c = 1'b0;
        end
    end
    assign qi.safe                    = safe_c;
    assign qi.cout                    = row == 3'd7;
    assign qi.last_queen_counter_zero = row == 3'd0;
    assign qi.last_cell               = cols[row] == 3'd7;
    assign qi.down_counter_zero       = dcnt == 3'd0;
    assign qi.out_ready               = ready_v[g];
    assign bus_v[g]   = qi.enable_output ? cols[dcnt] : 3'd0;
    assign valid_v[g] = qi.out_valid;
    assign last_v[g]  = qi.out_last;
    assign stb_v[g]   = {qi.reset_counter, qi.count_up, qi.count_down, qi.shift_right,
                         qi.load_counter, qi.count, qi.enable_output};
    always @(posedge clk) begin
      if (qi.reset_counter) begin
        row <= 3'd0;
        for (int i = 0; i < 8; i++) cols[i] <= 3'd0;
      end
      if (qi.count_up) begin
        row                <= row + 3'd1;
        cols[row + 3'd1]   <= 3'd0;
      end
      if (qi.count_down)   row       <= row - 3'd1;
      if (qi.shift_right)  cols[row] <= cols[row] + 3'd1;
      if (qi.load_counter) dcnt      <= 3'd7;
      if (qi.count)        dcnt      <= dcnt - 3'd1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle_check(input int i);
    logic [6:0] s;
    int         k;
    int         lim;
    s   = stb_v[i];
    lim = i == 1 ? 736 : 8;
    chk("strobe_onehot", int'($countones(s[6:1]) <= 1), 1);
    chk("up_with_down", int'(s[5] & s[4]), 0);
    chk("busy_with_done", int'(busy_v[i] & done_v[i]), 0);
    chk("count_without_accept", int'(s[1] & !(valid_v[i] & ready_v[i])), 0);
    if (start_v[i] && busy_v[i]) chk("start_while_busy", int'(s[6]), 0);
    if (hold[i]) begin
      chk("hold_valid", int'(valid_v[i]), 1);
      chk("hold_bus", int'(bus_v[i]), int'(pbus[i]));
      chk("hold_last", int'(last_v[i]), int'(plast[i]));
    end
    if (valid_v[i] && ready_v[i]) begin
      k = bcnt[i];
      if (k < lim) chk("beat_row", int'(bus_v[i]), sols[k / 8][7 - k % 8]);
      else chk("extra_beat", k, lim - 1);
      chk("beat_last", int'(last_v[i]), int'(k % 8 == 7));
      chk("beat_sol_count", int'(sc_v[i]), k / 8 + 1);
      bcnt[i]++;
    end
    hold[i]  = valid_v[i] && !ready_v[i] && !rst;
    pbus[i]  = bus_v[i];
    plast[i] = last_v[i];
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) cycle_check(i);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int i);
    chk("idle_strobes", int'(stb_v[i]), 0);
    chk("idle_valid", int'(valid_v[i]), 0);
    chk("idle_last", int'(last_v[i]), 0);
    chk("idle_busy", int'(busy_v[i]), 0);
    chk("idle_done", int'(done_v[i]), 0);
    chk("idle_sol_count", int'(sc_v[i]), 0);
  endtask

  initial begin
    int c [8];
    int r;
    int t;
    bit ok;
    int first [8];
    int last_sol [8];
    first    = '{0, 4, 7, 5, 2, 6, 1, 3};
    last_sol = '{7, 3, 0, 2, 5, 1, 6, 4};
    rst        = 1'b1;
    start_v    = '{1'b0, 1'b0};
    ready_v    = '{1'b1, 1'b1};
    bcnt       = '{0, 0};
    hold       = '{1'b0, 1'b0};
    // Reference: plain column-by-column backtracking, solutions in lexicographic order.
    r = 0; c = '{0, 0, 0, 0, 0, 0, 0, 0}; nsol = 0;
    while (r >= 0) begin
      if (c[r] > 7) begin
        r--;
        if (r >= 0) c[r]++;
      end else begin
        ok = 1'b1;
        for (int j = 0; j < r; j++)
          if (c[j] == c[r] || c[j] - c[r] == r - j || c[r] - c[j] == r - j) ok = 1'b0;
        if (!ok) c[r]++;
        else if (r == 7) begin
          if (nsol < 92) sols[nsol] = c;
          nsol++;
          c[r]++;
        end else begin
          r++;
          c[r] = 0;
        end
      end
    end
    chk("model_count", nsol, 92);
    for (int j = 0; j < 8; j++) chk("model_first", sols[0][j], first[j]);
    for (int j = 0; j < 8; j++) chk("model_last", sols[91][j], last_sol[j]);

    repeat (3) tick();
    for (int i = 0; i < 2; i++) check_idle(i);
    rst = 1'b0;
    tick();
    start_v = '{1'b1, 1'b1};
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("start_strobe", int'(stb_v[i]), 7'b1000000);
    @(posedge clk);
    #1;
    start_v = '{1'b0, 1'b0};
    for (int i = 0; i < 2; i++) chk("busy_after_start", int'(busy_v[i]), 1);

    t = 0;
    while (!(valid_v[1] && bcnt[1] == 3) && t < 5000) begin tick(); t++; end
    chk("reach_stream", int'(valid_v[1] && bcnt[1] == 3), 1);
    ready_v[1] = 1'b0;
    repeat (5) tick();
    chk("hold_no_beat", bcnt[1], 3);
    chk("hold_still_valid", int'(valid_v[1]), 1);
    ready_v[1] = 1'b1;

    t = 0;
    while (bcnt[1] < 40 && t < 20000) begin tick(); t++; end
    chk("busy_before_pulse", int'(busy_v[1]), 1);
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;

    t = 0;
    while (!(done_v[0] && done_v[1]) && t < 60000) begin tick(); t++; end
    chk("done_in_budget", int'(done_v[0] && done_v[1]), 1);
    repeat (3) tick();
    chk("first_beats", bcnt[0], 8);
    chk("first_sol_count", int'(sc_v[0]), 1);
    chk("first_done", int'(done_v[0]), 1);
    chk("all_beats", bcnt[1], 736);
    chk("all_sol_count", int'(sc_v[1]), 92);
    chk("all_done", int'(done_v[1]), 1);
    chk("all_not_busy", int'(busy_v[1]), 0);

    bcnt[1]    = 0;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    chk("restart_cleared", int'(sc_v[1]), 0);
    chk("restart_done_low", int'(done_v[1]), 0);
    chk("restart_busy", int'(busy_v[1]), 1);
    repeat (300) tick();
    chk("mid_search_busy", int'(busy_v[1]), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 2; i++) check_idle(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
